hamming_secded_decoder_pipe: RTL

Parametrised, pipelined Hamming SEC-DED decoder for the memory-protection read path. It corrects single-bit errors, detects double-bit errors, and moves data through a two-stage valid/ready pipeline with backpressure. It also keeps saturating corrected and uncorrectable event counters for scrubbing and telemetry logic.

---
 rtl/hamming_secded_decoder_pipe_if.sv | 46 ++++
 rtl/hamming_secded_decoder_pipe.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_decoder_pipe_if.sv
// Valid/ready bus for the SEC-DED read-path decoder: codeword in, decoded beat plus
// error flags out, and the event-counter clear/readback.
interface hamming_secded_decoder_pipe_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    function automatic int calc_par_w(input int dw);
        int r;
        r = 1;
        for (int i = 0; i < 16; i++) begin
            if ((1 << r) < (dw + r + 1)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    localparam int PAR_W  = calc_par_w(DATA_W);
    localparam int CODE_W = DATA_W + PAR_W + 1;

    logic [CODE_W-1:0] in_code;
    logic              in_valid;
    logic              in_ready;
    logic              correct_en;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [PAR_W-1:0]  out_syndrome;
    logic              err_corrected;
    logic              err_uncorrectable;
    logic              cnt_clr;
    logic [CNT_W-1:0]  corr_count;
    logic [CNT_W-1:0]  uncorr_count;

    modport master (
        output in_code, in_valid, correct_en, out_ready, cnt_clr,
        input  in_ready, out_data, out_valid, out_syndrome,
               err_corrected, err_uncorrectable, corr_count, uncorr_count
    );

    modport slave (
        input  in_code, in_valid, correct_en, out_ready, cnt_clr,
        output in_ready, out_data, out_valid, out_syndrome,
               err_corrected, err_uncorrectable, corr_count, uncorr_count
    );
endinterface

// File: rtl/hamming_secded_decoder_pipe.sv
// Two-stage pipelined Hamming SEC-DED decoder with valid/ready backpressure and
// saturating corrected/uncorrectable event counters.
module hamming_secded_decoder_pipe #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input logic                        clk,
    input logic                        rst_n,
    hamming_secded_decoder_pipe_if.slave bus
);
    function automatic int calc_par_w(input int dw);
        int r;
        r = 1;
        for (int i = 0; i < 16; i++) begin
            if ((1 << r) < (dw + r + 1)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    localparam int                PAR_W   = calc_par_w(DATA_W);
    localparam int                CODE_W  = DATA_W + PAR_W + 1;
    localparam logic [PAR_W-1:0]  MAX_POS = PAR_W'(CODE_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    // Syndrome bit k covers every position (excluding overall parity bit 0) with index bit k set.
    function automatic logic [PAR_W-1:0] f_syndrome(input logic [CODE_W-1:0] code);
        logic [PAR_W-1:0] s;
        s = '0;
        for (int k = 0; k < PAR_W; k++) begin
            for (int pos = 1; pos < CODE_W; pos++) begin
                s[k] = s[k] ^ (code[pos] & pos[k]);
            end
        end
        return s;
    endfunction

    function automatic logic f_overall_parity(input logic [CODE_W-1:0] code);
        return ^code;
    endfunction

    // Data bits sit at the non-power-of-two positions, in ascending order.
    function automatic logic [DATA_W-1:0] f_extract(input logic [CODE_W-1:0] code);
        logic [DATA_W-1:0] d;
        int                idx;
        d   = '0;
        idx = 0;
        for (int pos = 1; pos < CODE_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[idx] = code[pos];
                idx    = idx + 1;
            end else begin
                idx = idx;
            end
        end
        return d;
    endfunction

    logic              advance_s;
    logic              consume_s;
    logic [PAR_W-1:0]  syn_d;
    logic              par_d;

    logic              s1_valid_q;
    logic [CODE_W-1:0] s1_code_q;
    logic [PAR_W-1:0]  s1_syn_q;
    logic              s1_par_q;
    logic              s1_cen_q;

    logic              do_flip_s;
    logic [CODE_W-1:0] fixed_s;
    logic [DATA_W-1:0] data_d;
    logic              corr_d;
    logic              uncorr_d;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [PAR_W-1:0]  out_syn_q;
    logic              err_corr_q;
    logic              err_uncorr_q;
    logic [CNT_W-1:0]  corr_cnt_q;
    logic [CNT_W-1:0]  uncorr_cnt_q;

    assign advance_s = !out_valid_q || bus.out_ready;
    assign consume_s = out_valid_q && bus.out_ready;
    assign syn_d     = f_syndrome(bus.in_code);
    assign par_d     = f_overall_parity(bus.in_code);

    // Stage 1: capture the codeword with its syndrome and overall parity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_code_q  <= '0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
            s1_cen_q   <= 1'b0;
        end else if (advance_s) begin
            s1_valid_q <= bus.in_valid;
            s1_code_q  <= bus.in_code;
            s1_syn_q   <= syn_d;
            s1_par_q   <= par_d;
            s1_cen_q   <= bus.correct_en;
        end
    end

    // Classify the stage-1 beat and build the corrected codeword.
    always_comb begin
        corr_d    = 1'b0;
        uncorr_d  = 1'b0;
        do_flip_s = 1'b0;
        fixed_s   = s1_code_q;
        if (s1_syn_q == '0) begin
            corr_d = s1_par_q;
        end else if (s1_par_q) begin
            if (s1_syn_q <= MAX_POS) begin
                corr_d    = 1'b1;
                do_flip_s = s1_cen_q;
            end else begin
                uncorr_d = 1'b1;
            end
        end else begin
            uncorr_d = 1'b1;
        end
        for (int pos = 1; pos < CODE_W; pos++) begin
            fixed_s[pos] = s1_code_q[pos] ^ (do_flip_s && (PAR_W'(pos) == s1_syn_q));
        end
        data_d = f_extract(fixed_s);
    end

    // Stage 2: output beat register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_syn_q    <= '0;
            err_corr_q   <= 1'b0;
            err_uncorr_q <= 1'b0;
        end else if (advance_s) begin
            out_valid_q  <= s1_valid_q;
            out_data_q   <= data_d;
            out_syn_q    <= s1_syn_q;
            err_corr_q   <= corr_d;
            err_uncorr_q <= uncorr_d;
        end
    end

    // Saturating event counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            if (consume_s && err_corr_q && (corr_cnt_q != CNT_MAX)) begin
                corr_cnt_q <= corr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (consume_s && err_uncorr_q && (uncorr_cnt_q != CNT_MAX)) begin
                uncorr_cnt_q <= uncorr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.in_ready          = advance_s;
    assign bus.out_valid         = out_valid_q;
    assign bus.out_data          = out_data_q;
    assign bus.out_syndrome      = out_syn_q;
    assign bus.err_corrected     = err_corr_q;
    assign bus.err_uncorrectable = err_uncorr_q;
    assign bus.corr_count        = corr_cnt_q;
    assign bus.uncorr_count      = uncorr_cnt_q;
endmodule
